// File: rtl/synth_pkg.sv
// Shared types and constants for the tone synthesiser.
package synth_pkg;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  localparam int unsigned AMP_W     = 15;
  localparam int unsigned AMP_SUM_W = AMP_W + 1;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned PHASE_W   = 32;

  localparam logic [AMP_W-1:0] AMP_MAX = 15'd32767;

  // Apply the square-wave sign to a non-negative amplitude.
  function automatic logic [SAMPLE_W-1:0] signed_amp(input logic neg,
                                                     input logic [AMP_W-1:0] amp);
    logic [SAMPLE_W-1:0] mag;
    mag = {1'b0, amp};
    return neg ? (~mag + SAMPLE_W'(1)) : mag;
  endfunction

endpackage

// File: rtl/tone_synth_sample_tick.sv
// Sample-rate divider: one-cycle tick every clk_div_p clocks.
module sample_tick #(
  parameter int unsigned clk_div_p = 512
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_div_p - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count; tick flop is high exactly while the count sits at its last value.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == CNT_LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone synthesiser with linear attack/release envelope and
// a single-entry valid/ready sample output.
module tone_synth
  import synth_pkg::*;
#(
  parameter int unsigned clk_div_p  = 512,
  parameter int unsigned env_step_p = 1024
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [PHASE_W-1:0]  fstep_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overrun_o,
  output logic                busy_o
);

  localparam logic [AMP_SUM_W-1:0] STEP = AMP_SUM_W'(env_step_p);

  logic tick;

  env_state_t          state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  fstep_q, fstep_d;
  logic [AMP_W-1:0]    amp_q, amp_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;

  logic [AMP_SUM_W-1:0] amp_sum;
  logic [AMP_W-1:0]     amp_up;
  logic [AMP_W-1:0]     amp_dn;

  sample_tick #(
    .clk_div_p(clk_div_p)
  ) u_tick (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .tick_o (tick)
  );

  // Saturating envelope steps.
  always_comb begin
    amp_sum = {1'b0, amp_q} + STEP;
    amp_up  = (amp_sum > {1'b0, AMP_MAX}) ? AMP_MAX : amp_sum[AMP_W-1:0];
    amp_dn  = ({1'b0, amp_q} <= STEP) ? '0 : AMP_W'({1'b0, amp_q} - STEP);
  end

  // Envelope FSM, phase accumulator, sample formation and output handshake.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    fstep_d   = fstep_q;
    amp_d     = amp_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (tick) begin
      phase_d = phase_q + fstep_q;
      case (state_q)
        IDLE: begin
          amp_d = '0;
          if (fstep_i != '0) begin
            fstep_d = fstep_i;
            phase_d = '0;
            state_d = ATTACK;
          end
        end
        ATTACK: begin
          if (fstep_i != fstep_q) begin
            state_d = RELEASE;
          end else begin
            amp_d = amp_up;
            if (amp_up == AMP_MAX) state_d = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (fstep_i != fstep_q) state_d = RELEASE;
        end
        RELEASE: begin
          amp_d = amp_dn;
          if (amp_dn == '0) begin
            if (fstep_i != '0) begin
              fstep_d = fstep_i;
              phase_d = '0;
              state_d = ATTACK;
            end else begin
              fstep_d = '0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // New sample always replaces the output register; flag a lost one.
      sample_d  = signed_amp(phase_d[PHASE_W-1], amp_d);
      valid_d   = 1'b1;
      overrun_d = valid_q & ~ready_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      fstep_q   <= '0;
      amp_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      fstep_q   <= fstep_d;
      amp_q     <= amp_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign sample_o  = sample_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth with a cycle-level reference model.
module tb_tone_synth;

  localparam int DIV  = 4;
  localparam int STEP = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fstep;
  logic        ready;
  logic [15:0] sample_o;
  logic        valid_o;
  logic        overrun_o;
  logic        busy_o;

  int vectors    = 0;
  int miscompares = 0;

  tone_synth #(
    .clk_div_p (DIV),
    .env_step_p(STEP)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .fstep_i  (fstep),
    .sample_o (sample_o),
    .valid_o  (valid_o),
    .ready_i  (ready),
    .overrun_o(overrun_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: note mode 0 silent, 1 rising, 2 holding, 3 falling.
  int          m_cnt   = 0;
  logic [31:0] m_phase = 0;
  logic [31:0] m_fq    = 0;
  int          m_amp   = 0;
  int          m_mode  = 0;
  logic signed [15:0] e_sample = 0;
  bit          e_valid = 0, e_over = 0, e_busy = 0, m_fresh = 0;
  bit          check_en = 0;

  always @(posedge clk) begin : model
    bit tk;
    bit load;
    int s;
    if (reset) begin
      m_cnt = 0; m_phase = 0; m_fq = 0; m_amp = 0; m_mode = 0;
      e_sample = 0; e_valid = 0; e_over = 0; e_busy = 0; m_fresh = 0;
    end else begin
      tk      = (m_cnt == DIV - 1);
      m_cnt   = tk ? 0 : m_cnt + 1;
      m_fresh = tk;
      e_over  = 0;
      if (tk) begin
        m_phase = m_phase + m_fq;
        load = 0;
        case (m_mode)
          0: if (fstep != 0) load = 1;
          1: begin
            if (fstep != m_fq) m_mode = 3;
            else begin
              m_amp = (m_amp + STEP > 32767) ? 32767 : m_amp + STEP;
              if (m_amp == 32767) m_mode = 2;
            end
          end
          2: if (fstep != m_fq) m_mode = 3;
          3: begin
            m_amp = (m_amp > STEP) ? m_amp - STEP : 0;
            if (m_amp == 0) begin
              if (fstep != 0) load = 1;
              else begin m_fq = 0; m_mode = 0; end
            end
          end
          default: m_mode = 0;
        endcase
        if (load) begin m_fq = fstep; m_phase = 0; m_mode = 1; end
        s = m_phase[31] ? -m_amp : m_amp;
        e_sample = 16'(s);
        e_over   = e_valid && !ready;
        e_valid  = 1;
      end else if (e_valid && ready) begin
        e_valid = 0;
      end
      e_busy = (m_mode != 0);
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("sample",  32'($signed(sample_o)), 32'(e_sample));
      chk("valid",   32'(valid_o),   32'(e_valid));
      chk("overrun", 32'(overrun_o), 32'(e_over));
      chk("busy",    32'(busy_o),    32'(e_busy));
    end
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Advance to the next negedge at which a freshly ticked sample is visible.
  task automatic next_out(output int s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_fresh && n < 4 * DIV);
    if (!m_fresh) begin
      vectors++;
      miscompares++;
      $display("FAIL next_out: no tick within %0d cycles at %0t", n, $time);
    end
    s = 32'($signed(sample_o));
  endtask

  int atk [5]  = '{0, 8192, -16384, -24576, 32767};
  int rel [5]  = '{32767, 24575, 16383, 8191, 0};
  int wrp [10] = '{0, -8192, -16384, 24576, 32767, -32767, -32767, 32767, 32767, -32767};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s, s1, s2, n;
    reset = 1'b1;
    fstep = 32'h0;
    ready = 1'b1;
    @(negedge clk);
    check_en = 1;
    @(negedge clk);
    chk("rst_sample", 32'($signed(sample_o)), 0);
    chk("rst_valid",  32'(valid_o), 0);
    chk("rst_busy",   32'(busy_o), 0);
    reset = 1'b0;
    @(negedge clk);

    // Attack ramp from IDLE.
    fstep = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      next_out(s);
      chk("attack", s, atk[i]);
    end
    chk("sustain_busy", 32'(busy_o), 1);

    // Note change: release then re-attack on the new step.
    fstep = 32'h2000_0000;
    for (int i = 0; i < 5; i++) begin
      next_out(s);
      chk("release_amp", iabs(s), rel[i]);
    end
    next_out(s); chk("reattack1", s, 8192);
    next_out(s); chk("reattack2", s, 16384);
    next_out(s); chk("reattack3", s, 24576);
    next_out(s); chk("reattack4", s, -32767);

    // Note to silence.
    fstep = 32'h0;
    for (int i = 0; i < 5; i++) begin
      next_out(s);
      chk("silence_rel", iabs(s), rel[i]);
    end
    chk("idle_busy", 32'(busy_o), 0);
    for (int i = 0; i < 3; i++) begin
      next_out(s);
      chk("idle_sample", s, 0);
      chk("idle_valid",  32'(valid_o), 1);
    end
    @(negedge clk);
    chk("idle_valid_clr", 32'(valid_o), 0);

    // Backpressure across two ticks in SUSTAIN.
    fstep = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      next_out(s);
      chk("bp_attack", s, atk[i]);
    end
    @(negedge clk);
    ready = 1'b0;
    next_out(s1);
    chk("bp_s1", s1, 32767);
    chk("bp_ovr1", 32'(overrun_o), 0);
    next_out(s2);
    chk("bp_s2", s2, -32767);
    chk("bp_ovr2", 32'(overrun_o), 1);
    @(negedge clk);
    chk("bp_hold", 32'($signed(sample_o)), -32767);
    chk("bp_ovr_pulse", 32'(overrun_o), 0);
    chk("bp_hold_valid", 32'(valid_o), 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("bp_valid_clr", 32'(valid_o), 0);
    ready = 1'b1;

    // Reset mid-note, then replay the attack.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_sample", 32'($signed(sample_o)), 0);
    chk("mrst_valid",  32'(valid_o), 0);
    chk("mrst_busy",   32'(busy_o), 0);
    fstep = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      next_out(s);
      chk("replay", s, atk[i]);
    end

    // Phase wrap with a large step.
    fstep = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 40);
    chk("wrap_idle", 32'(busy_o), 0);
    fstep = 32'hC000_0000;
    for (int i = 0; i < 10; i++) begin
      next_out(s);
      chk("wrap", s, wrp[i]);
    end

    // Accept coinciding with a tick: no overrun.
    ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != DIV - 1 && n < 2 * DIV);
    chk("awt_valid_pre", 32'(valid_o), 1);
    ready = 1'b1;
    @(negedge clk);
    chk("awt_ovr",   32'(overrun_o), 0);
    chk("awt_valid", 32'(valid_o), 1);
    repeat (2 * DIV) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
Consumes the 32-bit frequency step produced by the song sequencer and synthesises a click-free square-wave audio stream. Contains a sample-rate divider, a 32-bit phase accumulator, and a linear attack/release envelope FSM. Emits signed 16-bit samples over a valid/ready handshake to the downstream audio serializer.
- fstep_i == 0 means silence (pause/done).

Parameters:
- clk_div_p, 512: clock cycles per sample tick (>= 2).
- env_step_p, 1024: amplitude change per tick during attack/release (1..32767).

Ports:
- clk_i, input, 1: system clock.
- reset_i, input, 1: synchronous, active-high reset.
- fstep_i, input, 32: requested phase increment per sample; 0 = silence.
- sample_o, output, 16: signed two's-complement sample.
- valid_o, output, 1: sample_o holds an unconsumed sample.
- ready_i, input, 1: consumer accepts sample_o when valid_o & ready_i.
- overrun_o, output, 1: 1-cycle pulse when an unconsumed sample is overwritten.
- busy_o, output, 1: envelope state != IDLE.

Behaviour:
- Reset: tick counter 0, phase 0, fstep_q 0, amp 0, state IDLE, sample_o 0, valid_o 0, overrun_o 0, busy_o 0. Reset mid-note silences output the next cycle; no release ramp.
- Tick: the divider counts 0..clk_div_p-1 and asserts tick for one cycle when the count is clk_div_p-1, then wraps to 0. All phase, amplitude and state updates happen only on tick cycles.
- Phase: on each tick, phase <= phase + fstep_q, modulo 2^32 (wrap is silent). Only fstep_q, the active step, is used; fstep_i never drives the accumulator directly.
- Envelope FSM, evaluated on each tick:
  - IDLE: amp is 0. If fstep_i != 0: load fstep_q <= fstep_i, set phase <= 0, go to ATTACK. This loading tick outputs sample 0.
  - ATTACK: if fstep_i != fstep_q, go to RELEASE with no amp change this tick. Otherwise amp <= min(amp + env_step_p, 32767); when the result is 32767, go to SUSTAIN.
  - SUSTAIN: if fstep_i != fstep_q, go to RELEASE.
  - RELEASE: amp <= max(amp - env_step_p, 0), saturating. When the result is 0:
    - if fstep_i != 0 on that tick: load fstep_q <= fstep_i, phase <= 0, go to ATTACK;
    - else fstep_q <= 0, go to IDLE.
  - Changes to fstep_i during RELEASE do not restart the release; only the value present on the final tick is loaded.
- Sample formation, on each tick after the updates: sample = phase[31] ? -amp : +amp, using the updated phase and amp, sign-extended to 16 bits. The range is ±32767; -32768 is never produced.
- Handshake:
  - Latency: sample_o and valid_o update on the clock edge ending the tick cycle and are visible 1 cycle after tick.
  - valid_o clears on the cycle after valid_o & ready_i with no new tick.
  - If a tick coincides with valid_o & ~ready_i, the new sample overwrites sample_o, valid_o stays 1, and overrun_o pulses for 1 cycle.
  - If a tick coincides with valid_o & ready_i, the old sample is consumed, the new one is loaded, valid_o stays 1, and there is no overrun.
  - sample_o is stable while valid_o & ~ready_i and no tick occurs.
  - A sample is produced every tick, including silent 0 samples in IDLE.
- busy_o reflects the registered state. It is 1 from the cycle after the loading tick until the cycle after the tick that enters IDLE.

Decomposition:
- Package synth_pkg holds:
  - typedef enum logic [1:0] env_state_t {IDLE, ATTACK, SUSTAIN, RELEASE};
  - localparam AMP_MAX = 15'd32767;
  - the sample width constant, 16.
- One sub-module, sample_tick: a parameterised clk_div_p divider with clk_i/reset_i inputs and a tick_o output.

Test Plan:
- Attack ramp: clk_div_p=4, env_step_p=8192, ready_i=1, fstep_i=0x4000_0000 applied from IDLE.
  - Loading tick outputs 0.
  - Subsequent samples: +8192 (0x2000), -16384 (0xC000), -24576 (0xA000), +32767 (0x7FFF); state reaches SUSTAIN.
- Note change with release: in SUSTAIN at amp 32767, switch fstep_i to 0x2000_0000.
  - Amp sequence 24575, 16383, 8191, 0.
  - On the zero tick fstep_q=0x2000_0000, phase=0, state ATTACK.
- Note to silence: in SUSTAIN, set fstep_i=0.
  - Release completes to amp 0, state IDLE, busy_o=0.
  - Afterwards samples are 0 every tick with valid_o still pulsing.
- Backpressure: hold ready_i=0 across 2 ticks.
  - Exactly one overrun_o pulse at the second tick.
  - sample_o equals the second sample; raising ready_i for 1 cycle clears valid_o.
- Reset mid-note: assert reset_i for 1 cycle while in SUSTAIN.
  - Next cycle: sample_o=0, valid_o=0, busy_o=0, phase=0.
  - A following fstep_i=0x4000_0000 replays the attack-ramp sequence exactly.
- Phase wrap and accept-with-tick:
  - fstep_i=0xC000_0000 runs 10 ticks: phase follows 0xC000_0000, 0x8000_0000, 0x4000_0000, 0x0..., with the sign pattern matching bit 31.
  - A tick coinciding with ready_i=1 produces no overrun.
